// File: rtl/alu_if.sv
// Operand/result bundle for the 16-bit ALU.
// The master side presents operands and op; the slave side (the ALU) returns
// the registered result, its flags and the result-valid strobe.
interface alu_if;
    logic [15:0] ALU_in1;
    logic [15:0] ALU_in2;
    logic [1:0]  op;
    logic        in_valid;
    logic [15:0] ALU_out;
    logic        out_valid;
    logic        zero;
    logic        neg;
    logic        carry;
    logic        ovf;

    modport master (
        output ALU_in1, ALU_in2, op, in_valid,
        input  ALU_out, out_valid, zero, neg, carry, ovf
    );

    modport slave (
        input  ALU_in1, ALU_in2, op, in_valid,
        output ALU_out, out_valid, zero, neg, carry, ovf
    );
endinterface

// File: rtl/alu.sv
// 16-bit ALU: ADD / SUB / AND / OR with one cycle of latency.
// Result and flags are registered together; with no valid input they hold,
// and out_valid marks the single cycle following an accepted operation.
module alu (
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_e;

    // Signed overflow on addition: like-signed operands, result sign flipped.
    function automatic logic add_ovf(input logic signed [15:0] a,
                                     input logic signed [15:0] b,
                                     input logic signed [15:0] r);
        return (a[15] == b[15]) && (r[15] != a[15]);
    endfunction

    // Signed overflow on subtraction: unlike-signed operands, result sign
    // differs from the minuend.
    function automatic logic sub_ovf(input logic signed [15:0] a,
                                     input logic signed [15:0] b,
                                     input logic signed [15:0] r);
        return (a[15] != b[15]) && (r[15] != a[15]);
    endfunction

    logic signed [15:0] a_s;
    logic signed [15:0] b_s;
    logic        [16:0] sum17;
    logic        [16:0] diff17;
    logic signed [15:0] res_s;
    logic               res_carry;
    logic               res_ovf;

    logic [15:0] result_q, result_d;
    logic        zero_q,   zero_d;
    logic        neg_q,    neg_d;
    logic        carry_q,  carry_d;
    logic        ovf_q,    ovf_d;
    logic        vld_p1_q, vld_p1_d;

    assign a_s = bus.ALU_in1;
    assign b_s = bus.ALU_in2;

    // Operation decode and next-state: load on valid input, otherwise hold.
    always_comb begin
        sum17     = {1'b0, bus.ALU_in1} + {1'b0, bus.ALU_in2};
        // Bit 16 of the zero-extended difference is the unsigned borrow.
        diff17    = {1'b0, bus.ALU_in1} - {1'b0, bus.ALU_in2};
        res_s     = '0;
        res_carry = 1'b0;
        res_ovf   = 1'b0;

        case (op_e'(bus.op))
            OP_ADD: begin
                res_s     = sum17[15:0];
                res_carry = sum17[16];
                res_ovf   = add_ovf(a_s, b_s, sum17[15:0]);
            end
            OP_SUB: begin
                res_s     = diff17[15:0];
                res_carry = diff17[16];
                res_ovf   = sub_ovf(a_s, b_s, diff17[15:0]);
            end
            OP_AND:  res_s = a_s & b_s;
            OP_OR:   res_s = a_s | b_s;
            default: res_s = '0;
        endcase

        result_d = result_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        vld_p1_d = bus.in_valid;

        // Inputs are only looked at when qualified, so idle-cycle garbage
        // never reaches the registers.
        if (bus.in_valid) begin
            result_d = res_s;
            zero_d   = (res_s == 16'sd0);
            neg_d    = res_s[15];
            carry_d  = res_carry;
            ovf_d    = res_ovf;
        end
    end

    // Result register; reset wins over any op presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            vld_p1_q <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            vld_p1_q <= vld_p1_d;
        end
    end

    assign bus.ALU_out   = result_q;
    assign bus.out_valid = vld_p1_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
    assign bus.carry     = carry_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for the 16-bit ALU: a table of directed vectors plus
// hand-written hold/reset sequences and a random stream, all checked through
// an expected-result queue.
module tb_alu;

    typedef struct packed {
        logic [15:0] out;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        res_t        exp;
    } vec_t;

    localparam int NVEC = 13;

    logic clk;
    logic rst;
    alu_if bus ();

    alu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    res_t expq[$];
    res_t last_exp;
    vec_t vecs[NVEC];

    // Reference behaviour computed in plain integer arithmetic.
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic [1:0] op);
        res_t r;
        int ua, ub, sa, sb, u, s;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = '0;
        case (op)
            2'd0: begin
                u = ua + ub; s = sa + sb;
                r.out = u[15:0];
                r.c = (u > 65535);
                r.v = (s > 32767) || (s < -32768);
            end
            2'd1: begin
                u = ua - ub; s = sa - sb;
                r.out = u[15:0];
                r.c = (ua < ub);
                r.v = (s > 32767) || (s < -32768);
            end
            2'd2: r.out = a & b;
            default: r.out = a | b;
        endcase
        r.z = (r.out == 16'h0000);
        r.n = r.out[15];
        return r;
    endfunction

    task automatic chk(input string name, input res_t exp, input logic exp_vld);
        res_t act;
        act = '{bus.ALU_out, bus.zero, bus.neg, bus.carry, bus.ovf};
        checks++;
        if (act !== exp || bus.out_valid !== exp_vld) begin
            errors++;
            $display("FAIL %s: got out=%h z=%b n=%b c=%b v=%b vld=%b, want out=%h z=%b n=%b c=%b v=%b vld=%b",
                     name, act.out, act.z, act.n, act.c, act.v, bus.out_valid,
                     exp.out, exp.z, exp.n, exp.c, exp.v, exp_vld);
        end
    endtask

    // Present one cycle of stimulus; accepted ops queue their expectation.
    task automatic drive(input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] op, input logic valid, input res_t exp);
        bus.ALU_in1  = a;
        bus.ALU_in2  = b;
        bus.op       = op;
        bus.in_valid = valid;
        if (valid && !rst) expq.push_back(exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare the queue head against the output produced after the last edge.
    task automatic pop_chk(input string name);
        res_t e;
        if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got out=%h vld=%b, want a queued result",
                     name, bus.ALU_out, bus.out_valid);
        end else begin
            e = expq.pop_front();
            last_exp = e;
            chk(name, e, 1'b1);
        end
    endtask

    initial begin
        //             a         b         op    {out,     z,    n,    c,    v}
        vecs[0]  = '{16'h0000, 16'h0002, 2'd0, '{16'h0002, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[1]  = '{16'h0000, 16'h0002, 2'd1, '{16'hFFFE, 1'b0, 1'b1, 1'b1, 1'b0}};
        vecs[2]  = '{16'h2001, 16'h1044, 2'd0, '{16'h3045, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[3]  = '{16'h2001, 16'h1044, 2'd1, '{16'h0FBD, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[4]  = '{16'h2001, 16'h1044, 2'd2, '{16'h0000, 1'b1, 1'b0, 1'b0, 1'b0}};
        vecs[5]  = '{16'h2001, 16'h1044, 2'd3, '{16'h3045, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[6]  = '{16'h7FFF, 16'h0001, 2'd0, '{16'h8000, 1'b0, 1'b1, 1'b0, 1'b1}};
        vecs[7]  = '{16'hFFFF, 16'h0001, 2'd0, '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0}};
        vecs[8]  = '{16'h8000, 16'h0001, 2'd1, '{16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1}};
        vecs[9]  = '{16'hFFFF, 16'h8000, 2'd2, '{16'h8000, 1'b0, 1'b1, 1'b0, 1'b0}};
        vecs[10] = '{16'h8000, 16'h8000, 2'd0, '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b1}};
        vecs[11] = '{16'h0005, 16'h0005, 2'd1, '{16'h0000, 1'b1, 1'b0, 1'b0, 1'b0}};
        vecs[12] = '{16'h7FFF, 16'hFFFF, 2'd1, '{16'h8000, 1'b0, 1'b1, 1'b1, 1'b1}};

        last_exp = '0;
        rst = 1'b1;
        drive(16'h0000, 16'h0000, 2'd0, 1'b0, '0);
        tick();
        tick();

        // Reset with a valid op present: op discarded, everything cleared.
        drive(16'h1234, 16'h0001, 2'd0, 1'b1, '0);
        tick();
        chk("reset_state", '0, 1'b0);
        rst = 1'b0;

        // Directed vectors, back to back, op changing every cycle.
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].op, 1'b1, vecs[i].exp);
            tick();
            pop_chk($sformatf("vec%0d", i));
        end

        // Two idle cycles with garbage inputs: outputs hold, out_valid low.
        for (int i = 0; i < 2; i++) begin
            drive(16'($urandom), 16'($urandom), 2'($urandom), 1'b0, '0);
            tick();
            chk($sformatf("hold%0d", i), last_exp, 1'b0);
        end

        // Resume, then reset while an op is valid.
        drive(16'h1111, 16'h2222, 2'd0, 1'b1, model(16'h1111, 16'h2222, 2'd0));
        tick();
        pop_chk("resume");
        rst = 1'b1;
        drive(16'hFFFF, 16'hFFFF, 2'd0, 1'b1, '0);
        tick();
        chk("rst_priority", '0, 1'b0);
        rst = 1'b0;
        last_exp = '0;

        // First op after reset: normal result, no stale data.
        drive(16'h0003, 16'h0004, 2'd1, 1'b1, model(16'h0003, 16'h0004, 2'd1));
        tick();
        pop_chk("post_reset");

        // Random stream with random gaps, checked against the model.
        for (int i = 0; i < 60; i++) begin
            logic [15:0] a, b;
            logic [1:0]  op;
            logic        v;
            a  = 16'($urandom);
            b  = 16'($urandom);
            op = 2'($urandom_range(0, 3));
            v  = ($urandom_range(0, 3) != 0);
            drive(a, b, op, v, model(a, b, op));
            tick();
            if (v) pop_chk($sformatf("rnd%0d", i));
            else   chk($sformatf("rnd_hold%0d", i), last_exp, 1'b0);
        end

        if (expq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results left, want 0", expq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
